// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC burst trigger generator.
// Holds the FSM state encoding, the trigger-width select values and the
// default acknowledge-window length used by tdc_trig_gen and tdc_ack_window.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } tdc_state_e;

  localparam logic WIDTH_1CYC = 1'b0;
  localparam logic WIDTH_2CYC = 1'b1;

  localparam int ACK_WIN_DEF = 4;

endpackage

// File: rtl/tdc_trig_gen_if.sv
// Control/status bundle between the config block and tdc_trig_gen.
// master : config side (drives start/abort/cfg/sync, observes status)
// slave  : the trigger generator
//   start, abort, period_cfg, width_cfg, burst_cfg, sel_cfg, sync -> slave
//   TDC_trigger, s, busy, done, hit_cnt, miss_cnt, err_spur      <- slave
interface tdc_trig_gen_if #(
  parameter int PER_W = 16,
  parameter int CNT_W = 16
) ();

  logic             start;
  logic             abort;
  logic [PER_W-1:0] period_cfg;
  logic             width_cfg;
  logic [CNT_W-1:0] burst_cfg;
  logic             sel_cfg;
  logic             sync;

  logic             TDC_trigger;
  logic             s;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             err_spur;

  modport master (
    output start, abort, period_cfg, width_cfg, burst_cfg, sel_cfg, sync,
    input  TDC_trigger, s, busy, done, hit_cnt, miss_cnt, err_spur
  );

  modport slave (
    input  start, abort, period_cfg, width_cfg, burst_cfg, sel_cfg, sync,
    output TDC_trigger, s, busy, done, hit_cnt, miss_cnt, err_spur
  );

endinterface

// File: rtl/tdc_ack_window.sv
// Acknowledge-window tracker for the TDC trigger generator.
// Opens an ACK_WIN-cycle window the cycle after each trigger rise and
// classifies returning sync pulses as hit, miss or spurious.
//   clk5, rst_n : clock, async active-low reset
//   i_clr       : clear counters and sticky flag (burst start)
//   i_rise      : trigger rise strobe
//   i_sync      : acknowledge pulse from the synchroniser
//   i_abort     : burst aborted, discard open window
//   i_busy      : burst in progress
//   o_hit_cnt, o_miss_cnt, o_err_spur : saturating counters, sticky error
module tdc_ack_window
  import tdc_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int ACK_WIN = ACK_WIN_DEF
) (
  input  logic             clk5,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_rise,
  input  logic             i_sync,
  input  logic             i_abort,
  input  logic             i_busy,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt,
  output logic             o_err_spur
);

  logic [3:0]       r_win;
  logic             r_got;
  logic [CNT_W-1:0] r_hit;
  logic [CNT_W-1:0] r_miss;
  logic             r_spur;
  logic             w_open;

  // r_win holds the number of window cycles still to come, including this one
  assign w_open = (r_win != 4'd0) && i_busy;

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_win  <= 4'd0;
      r_got  <= 1'b0;
      r_hit  <= '0;
      r_miss <= '0;
      r_spur <= 1'b0;
    end else if (i_clr) begin
      r_win  <= 4'd0;
      r_got  <= 1'b0;
      r_hit  <= '0;
      r_miss <= '0;
      r_spur <= 1'b0;
    end else if (i_abort) begin
      r_win <= 4'd0;
      r_got <= 1'b0;
    end else begin
      if (i_rise) begin
        r_win <= 4'(ACK_WIN);
        r_got <= 1'b0;
      end else if (w_open) begin
        r_win <= r_win - 4'd1;
      end

      if (i_sync) begin
        if (w_open && !r_got) begin
          r_got <= 1'b1;
          if (r_hit != '1) r_hit <= r_hit + CNT_W'(1);
        end else begin
          r_spur <= 1'b1;
        end
      end

      // last window cycle with nothing seen: close as a miss
      if (w_open && (r_win == 4'd1) && !r_got && !i_sync) begin
        if (r_miss != '1) r_miss <= r_miss + CNT_W'(1);
      end
    end
  end

  assign o_hit_cnt  = r_hit;
  assign o_miss_cnt = r_miss;
  assign o_err_spur = r_spur;

endmodule

// File: rtl/tdc_trig_gen.sv
// Burst trigger generator for the TDC edge synchroniser.
// Issues burst_cfg trigger pulses spaced by max(period_cfg, ACK_WIN+2)
// cycles, holds the edge select on s for the whole burst and counts
// acknowledged / missed triggers via tdc_ack_window.
//   clk5  : system clock
//   rst_n : async active-low reset
//   bus   : tdc_trig_gen_if.slave (config/strobes in, trigger/status out)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start, s holds last select
// ST_HIGH | TDC_trigger asserted (1 or 2 cycles), period count from rise
// ST_LOW  | TDC_trigger low, waiting for period terminal count
// ST_DONE | one-cycle done pulse, then back to idle
module tdc_trig_gen
  import tdc_pkg::*;
#(
  parameter int PER_W   = 16,
  parameter int CNT_W   = 16,
  parameter int ACK_WIN = ACK_WIN_DEF
) (
  input  logic       clk5,
  input  logic       rst_n,
  tdc_trig_gen_if.slave bus
);

  localparam logic [PER_W-1:0] MIN_PER = PER_W'(ACK_WIN + 2);

  tdc_state_e       r_state;
  tdc_state_e       w_next;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_period;
  logic             r_width;
  logic [CNT_W-1:0] r_burst;
  logic [CNT_W-1:0] r_issued;
  logic             r_s;

  logic w_accept;
  logic w_abort;
  logic w_rise;
  logic w_busy;

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_abort  = bus.abort && (r_state != ST_IDLE);
  assign w_busy   = (r_state == ST_HIGH) || (r_state == ST_LOW);
  assign w_rise   = (r_state == ST_HIGH) && (r_cnt == '0) && !w_abort;

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_next = (bus.burst_cfg == '0) ? ST_DONE : ST_HIGH;
      ST_HIGH: if ((r_width == WIDTH_1CYC) || (r_cnt == PER_W'(1))) w_next = ST_LOW;
      ST_LOW:  if (r_cnt == r_period - PER_W'(1))
                 w_next = (r_issued < r_burst) ? ST_HIGH : ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_IDLE;
  end

  // period counter is 0 in the rise cycle
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_next == ST_HIGH) && (r_state != ST_HIGH)) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + PER_W'(1);
    end
  end

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_width  <= WIDTH_1CYC;
      r_burst  <= '0;
      r_issued <= '0;
      r_s      <= 1'b0;
    end else if (w_accept) begin
      r_period <= (bus.period_cfg < MIN_PER) ? MIN_PER : bus.period_cfg;
      r_width  <= bus.width_cfg;
      r_burst  <= bus.burst_cfg;
      r_issued <= '0;
      r_s      <= bus.sel_cfg;
    end else if (w_rise) begin
      r_issued <= r_issued + CNT_W'(1);
    end
  end

  tdc_ack_window #(
    .CNT_W  (CNT_W),
    .ACK_WIN(ACK_WIN)
  ) u_ack (
    .clk5      (clk5),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_rise    (w_rise),
    .i_sync    (bus.sync),
    .i_abort   (w_abort),
    .i_busy    (w_busy),
    .o_hit_cnt (bus.hit_cnt),
    .o_miss_cnt(bus.miss_cnt),
    .o_err_spur(bus.err_spur)
  );

  // abort kills the trigger and done combinationally in the same cycle
  assign bus.TDC_trigger = (r_state == ST_HIGH) && !w_abort;
  assign bus.done        = (r_state == ST_DONE) && !w_abort;
  assign bus.busy        = w_busy;
  assign bus.s           = r_s;

endmodule
